// File: rtl/qpu_exu_evt_tqueue.sv
// qpu_exu_evt_tqueue: stamps event write-backs with the QWAIT timeline and
// releases them to pulse generation when the system timer reaches the stamp.
module qpu_exu_evt_tqueue #(
    parameter int TIME_W   = 32,
    parameter int EDATA_W  = 16,
    parameter int OPRAND_W = 8,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_run,
    input  logic                   i_clr,
    input  logic                   twbck_i_valid,
    output logic                   twbck_i_ready,
    input  logic [TIME_W-1:0]      twbck_i_data,
    input  logic                   ewbck_i_valid,
    output logic                   ewbck_i_ready,
    input  logic [EDATA_W-1:0]     ewbck_i_data,
    input  logic [OPRAND_W-1:0]    ewbck_i_oprand,
    output logic                   trig_o_valid,
    output logic [EDATA_W-1:0]     trig_o_data,
    output logic [OPRAND_W-1:0]    trig_o_oprand,
    output logic                   trig_o_late,
    output logic [TIME_W-1:0]      o_timeline,
    output logic [TIME_W-1:0]      o_timer,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [15:0]            o_late_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TIME_W-1:0] HALF = {1'b1, {(TIME_W-1){1'b0}}};

    logic [TIME_W-1:0]   ts_mem   [DEPTH];
    logic [EDATA_W-1:0]  data_mem [DEPTH];
    logic [OPRAND_W-1:0] op_mem   [DEPTH];

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic [TIME_W-1:0]   tl;
    logic [TIME_W-1:0]   timer;
    logic [15:0]         late_cnt;

    logic                empty;
    logic                full;
    logic                t_hs;
    logic                push;
    logic                due;
    logic                late;
    logic [TIME_W-1:0]   tl_next;
    logic [TIME_W-1:0]   ts_in;
    logic [TIME_W-1:0]   head_ts;
    logic [TIME_W-1:0]   lag;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign twbck_i_ready = 1'b1;
    assign ewbck_i_ready = ~full;

    assign t_hs    = twbck_i_valid & twbck_i_ready;
    assign push    = ewbck_i_valid & ~full & ~i_clr;
    assign tl_next = tl + twbck_i_data;
    // An event arriving with a QWAIT in the same cycle lands after the wait.
    assign ts_in   = t_hs ? tl_next : tl;

    // Wrap-safe "timer has reached ts": lag below half range means due.
    assign head_ts = ts_mem[rd_ptr];
    assign lag     = timer - head_ts;
    assign due     = ~empty & (lag < HALF);
    assign late    = due & (timer != head_ts);

    assign trig_o_valid  = due;
    assign trig_o_late   = late;
    assign trig_o_data   = due ? data_mem[rd_ptr] : '0;
    assign trig_o_oprand = due ? op_mem[rd_ptr] : '0;

    assign o_timeline = tl;
    assign o_timer    = timer;
    assign o_count    = count;
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_late_cnt = late_cnt;

    // Event storage; contents are don't-care outside the valid window.
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr]   <= ts_in;
            data_mem[wr_ptr] <= ewbck_i_data;
            op_mem[wr_ptr]   <= ewbck_i_oprand;
        end
    end

    // FIFO pointers and occupancy; a due head pops on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (due)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !due)
                count <= count + 1'b1;
            else if (!push && due)
                count <= count - 1'b1;
        end
    end

    // Timeline accumulates QWAIT intervals; timer free-runs under i_run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tl    <= '0;
            timer <= '0;
        end else if (i_clr) begin
            tl    <= '0;
            timer <= '0;
        end else begin
            if (t_hs)  tl    <= tl_next;
            if (i_run) timer <= timer + 1'b1;
        end
    end

    // Saturating count of events released after their timestamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            late_cnt <= '0;
        else if (i_clr)
            late_cnt <= '0;
        else if (late && late_cnt != 16'hFFFF)
            late_cnt <= late_cnt + 1'b1;
    end

endmodule

// File: tb/tb_qpu_exu_evt_tqueue.sv
// tb_qpu_exu_evt_tqueue: directed stimulus with a release scoreboard;
// narrow timer width so the wrap case is reachable in a short run.
module tb_qpu_exu_evt_tqueue;

    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_run = 1'b0;
    logic          i_clr = 1'b0;
    logic          twbck_i_valid = 1'b0;
    logic          twbck_i_ready;
    logic [TW-1:0] twbck_i_data = '0;
    logic          ewbck_i_valid = 1'b0;
    logic          ewbck_i_ready;
    logic [15:0]   ewbck_i_data = '0;
    logic [7:0]    ewbck_i_oprand = '0;
    logic          trig_o_valid;
    logic [15:0]   trig_o_data;
    logic [7:0]    trig_o_oprand;
    logic          trig_o_late;
    logic [TW-1:0] o_timeline;
    logic [TW-1:0] o_timer;
    logic [3:0]    o_count;
    logic          o_empty;
    logic          o_full;
    logic [15:0]   o_late_cnt;

    qpu_exu_evt_tqueue #(
        .TIME_W(TW), .EDATA_W(16), .OPRAND_W(8), .DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_clr(i_clr),
        .twbck_i_valid(twbck_i_valid), .twbck_i_ready(twbck_i_ready),
        .twbck_i_data(twbck_i_data),
        .ewbck_i_valid(ewbck_i_valid), .ewbck_i_ready(ewbck_i_ready),
        .ewbck_i_data(ewbck_i_data), .ewbck_i_oprand(ewbck_i_oprand),
        .trig_o_valid(trig_o_valid), .trig_o_data(trig_o_data),
        .trig_o_oprand(trig_o_oprand), .trig_o_late(trig_o_late),
        .o_timeline(o_timeline), .o_timer(o_timer), .o_count(o_count),
        .o_empty(o_empty), .o_full(o_full), .o_late_cnt(o_late_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   data;
        logic [7:0]    op;
        logic          late;
        logic [TW-1:0] at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic twb(input logic [TW-1:0] d);
        twbck_i_valid = 1'b1;
        twbck_i_data  = d;
        tick();
        twbck_i_valid = 1'b0;
        twbck_i_data  = '0;
    endtask

    task automatic evt(input logic [15:0] d, input logic [7:0] op);
        ewbck_i_valid  = 1'b1;
        ewbck_i_data   = d;
        ewbck_i_oprand = op;
        tick();
        ewbck_i_valid  = 1'b0;
    endtask

    task automatic expect_rel(input logic [15:0] d, input logic [7:0] op,
                              input logic l, input logic [TW-1:0] at);
        sb.push_back('{data: d, op: op, late: l, at: at});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d releases pending expected 0",
                     sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_timer(input logic [TW-1:0] t, input int budget);
        int n = 0;
        while (o_timer != t && n < budget) begin
            tick();
            n++;
        end
        chk("wait_timer", 32'(o_timer), 32'(t));
    endtask

    // Release monitor: every strobe must match the oldest expected release.
    always @(negedge clk) begin
        if (trig_o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_release: got data 0x%0h at timer %0d expected none",
                         trig_o_data, o_timer);
            end else begin
                mon_e = sb.pop_front();
                chk("rel_data", 32'(trig_o_data), 32'(mon_e.data));
                chk("rel_oprand", 32'(trig_o_oprand), 32'(mon_e.op));
                chk("rel_late", 32'(trig_o_late), 32'(mon_e.late));
                chk("rel_timer", 32'(o_timer), 32'(mon_e.at));
            end
        end else begin
            chk("idle_zero", 32'({trig_o_data, trig_o_oprand, trig_o_late}), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        tick();
        tick();
        chk("rst_timeline", 32'(o_timeline), 32'd0);
        chk("rst_timer", 32'(o_timer), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full", 32'(o_full), 32'd0);
        chk("rst_tready", 32'(twbck_i_ready), 32'd1);
        chk("rst_eready", 32'(ewbck_i_ready), 32'd1);
        chk("rst_latecnt", 32'(o_late_cnt), 32'd0);
        rst_n = 1'b1;
        i_run = 1'b1;

        // Wait 10 then E1: stamped 10, fires at timer 10
        twb(8'd10);
        expect_rel(16'h0011, 8'h01, 1'b0, 8'd10);
        evt(16'h0011, 8'h01);
        drain(50);
        chk("t1_empty", 32'(o_empty), 32'd1);
        chk("t1_timeline", 32'(o_timeline), 32'd10);

        // Wait 5 in the same cycle as E2 at tl 20: stamped 25
        twb(8'd10);
        expect_rel(16'h0022, 8'h02, 1'b0, 8'd25);
        twbck_i_valid  = 1'b1;
        twbck_i_data   = 8'd5;
        ewbck_i_valid  = 1'b1;
        ewbck_i_data   = 16'h0022;
        ewbck_i_oprand = 8'h02;
        tick();
        twbck_i_valid = 1'b0;
        ewbck_i_valid = 1'b0;
        chk("t2_timeline", 32'(o_timeline), 32'd25);
        drain(50);

        // Three events sharing ts 40: consecutive releases, two late
        twb(8'd15);
        expect_rel(16'h0031, 8'h03, 1'b0, 8'd40);
        expect_rel(16'h0032, 8'h04, 1'b1, 8'd41);
        expect_rel(16'h0033, 8'h05, 1'b1, 8'd42);
        evt(16'h0031, 8'h03);
        evt(16'h0032, 8'h04);
        evt(16'h0033, 8'h05);
        drain(50);
        chk("t3_latecnt", 32'(o_late_cnt), 32'd2);
        chk("t3_empty", 32'(o_empty), 32'd1);

        // Timer halted: fill to DEPTH, ninth held until first release
        i_run = 1'b0;
        twb(8'd100);
        for (int i = 0; i < 8; i++) begin
            expect_rel(16'h0100 + 16'(i), 8'(1 << i), (i != 0), 8'(140 + i));
            evt(16'h0100 + 16'(i), 8'(1 << i));
        end
        chk("t4_full", 32'(o_full), 32'd1);
        chk("t4_count", 32'(o_count), 32'd8);
        chk("t4_eready", 32'(ewbck_i_ready), 32'd0);
        ewbck_i_valid  = 1'b1;
        ewbck_i_data   = 16'h0109;
        ewbck_i_oprand = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_held_count", 32'(o_count), 32'd8);
        end
        i_run = 1'b1;
        n = 0;
        while (ewbck_i_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t4_accept_timer", 32'(o_timer), 32'd141);
        expect_rel(16'h0109, 8'hFF, 1'b1, 8'd148);
        tick();
        ewbck_i_valid = 1'b0;
        drain(50);
        chk("t4_latecnt", 32'(o_late_cnt), 32'd10);
        chk("t4_timeline", 32'(o_timeline), 32'd140);

        // Wrap: tl 253 + 5 = 2, timer 253 must not fire early
        twb(8'd113);
        wait_timer(8'd253, 300);
        i_run = 1'b0;
        expect_rel(16'h0055, 8'h55, 1'b0, 8'd2);
        twbck_i_valid  = 1'b1;
        twbck_i_data   = 8'd5;
        ewbck_i_valid  = 1'b1;
        ewbck_i_data   = 16'h0055;
        ewbck_i_oprand = 8'h55;
        tick();
        twbck_i_valid = 1'b0;
        ewbck_i_valid = 1'b0;
        chk("t5_timeline", 32'(o_timeline), 32'd2);
        chk("t5_timer", 32'(o_timer), 32'd253);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_early", 32'(trig_o_valid), 32'd0);
            tick();
        end
        chk("t5_count", 32'(o_count), 32'd1);
        i_run = 1'b1;
        drain(20);

        // Reset with four queued events discards them
        i_run = 1'b0;
        twb(8'd100);
        for (int i = 0; i < 4; i++) evt(16'h0200 + 16'(i), 8'h0F);
        chk("t6_count4", 32'(o_count), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(o_count), 32'd0);
        chk("t6_rst_timeline", 32'(o_timeline), 32'd0);
        chk("t6_rst_timer", 32'(o_timer), 32'd0);
        chk("t6_rst_empty", 32'(o_empty), 32'd1);
        chk("t6_rst_valid", 32'(trig_o_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        expect_rel(16'h0066, 8'h06, 1'b0, 8'd0);
        evt(16'h0066, 8'h06);
        drain(10);

        // Late release, then i_clr with conflicting inputs
        i_run = 1'b1;
        expect_rel(16'h0077, 8'h07, 1'b1, 8'd1);
        evt(16'h0077, 8'h07);
        drain(10);
        chk("t7_latecnt", 32'(o_late_cnt), 32'd1);
        i_run = 1'b0;
        twb(8'd50);
        evt(16'h0301, 8'h01);
        evt(16'h0302, 8'h02);
        chk("t7_count2", 32'(o_count), 32'd2);
        chk("t7_timeline", 32'(o_timeline), 32'd50);
        i_clr          = 1'b1;
        i_run          = 1'b1;
        twbck_i_valid  = 1'b1;
        twbck_i_data   = 8'd7;
        ewbck_i_valid  = 1'b1;
        ewbck_i_data   = 16'h0399;
        ewbck_i_oprand = 8'h99;
        tick();
        i_clr         = 1'b0;
        i_run         = 1'b0;
        twbck_i_valid = 1'b0;
        ewbck_i_valid = 1'b0;
        chk("t7_clr_count", 32'(o_count), 32'd0);
        chk("t7_clr_timeline", 32'(o_timeline), 32'd0);
        chk("t7_clr_timer", 32'(o_timer), 32'd0);
        chk("t7_clr_latecnt", 32'(o_late_cnt), 32'd0);
        chk("t7_clr_empty", 32'(o_empty), 32'd1);
        expect_rel(16'h0088, 8'h08, 1'b0, 8'd0);
        evt(16'h0088, 8'h08);
        drain(10);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
